// File: rtl/asg_deser.sv
// asg_deser: assembles one packed TOTAL_W-bit variable assignment from an
// LSB-first stream of CHUNK_W-bit beats and hands it downstream through a
// valid/ready handshake. Framing errors (short/long frames) raise a
// single-cycle err_len pulse and never produce an assignment.
//
// Optional build macro ASG_COUNT_EN adds the asg_count (handshakes, wrapping)
// and err_count (error pulses, saturating) statistics outputs.
//
// state     | meaning
// S_FILL    | accepting beats, writing them into asg_data
// S_HOLD    | assignment complete, asg_valid high, waiting for asg_ready
// S_DISCARD | long frame detected, dropping beats until in_last
module asg_deser #(
  parameter int TOTAL_W = 551,
  parameter int CHUNK_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               asg_valid,
  input  logic               asg_ready,
  output logic [TOTAL_W-1:0] asg_data,
  output logic               err_len
`ifdef ASG_COUNT_EN
  ,
  output logic [31:0]        asg_count,
  output logic [15:0]        err_count
`endif
);

  localparam int NBEATS = (TOTAL_W + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_wr;
  logic               w_accept;
  logic [TOTAL_W-1:0] r_data;
  logic [TOTAL_W-1:0] w_mask;
  logic [TOTAL_W-1:0] w_rep;

  assign w_accept  = in_valid && in_ready;
  // Both flags decode the state register only, so asg_ready never reaches in_ready.
  assign in_ready  = (r_state != S_HOLD);
  assign asg_valid = (r_state == S_HOLD);
  assign asg_data  = r_data;
  assign err_len   = r_err;

  // The beat replicated across the whole vector; truncation drops the unused top
  // of the last beat, so those in_data bits never reach asg_data.
  assign w_rep = TOTAL_W'({NBEATS{in_data}});

  // Select the slice of asg_data owned by the current beat index.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < TOTAL_W; i++) begin
      w_mask[i] = (CNT_W'(i / CHUNK_W) == r_cnt);
    end
  end

  // State, beat counter and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, counter and framing-error decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_wr        = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_cnt_nxt = '0;
            if (in_last) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_state_nxt = S_DISCARD;
              w_err_nxt   = 1'b1;
            end
          end else if (in_last) begin
            w_cnt_nxt = '0;
            w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (asg_ready) begin
          w_state_nxt = S_FILL;
        end
      end
      S_DISCARD: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_FILL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Assignment register: only the current beat's slice is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_wr) begin
      r_data <= (r_data & ~w_mask) | (w_rep & w_mask);
    end
  end

`ifdef ASG_COUNT_EN
  logic [31:0] r_asg_count;
  logic [15:0] r_err_count;

  assign asg_count = r_asg_count;
  assign err_count = r_err_count;

  // Handshake counter wraps; error counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asg_count <= '0;
      r_err_count <= '0;
    end else begin
      if (asg_valid && asg_ready) begin
        r_asg_count <= r_asg_count + 32'd1;
      end
      if (r_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_asg_deser.sv
// Testbench for asg_deser: directed framing scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_asg_deser;

  localparam int TOTAL_W = 551;
  localparam int CHUNK_W = 32;
  localparam int NBEATS  = 18;
  localparam int MAXB    = NBEATS + 4;

  typedef logic [TOTAL_W-1:0] wide_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_data;
  logic               in_last;
  logic               asg_valid;
  logic               asg_ready;
  logic [TOTAL_W-1:0] asg_data;
  logic               err_len;
`ifdef ASG_COUNT_EN
  logic [31:0]        asg_count;
  logic [15:0]        err_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_good = 0;
  int exp_bad = 0;
  logic [CHUNK_W-1:0] beat_mem [MAXB];

  asg_deser #(.TOTAL_W(TOTAL_W), .CHUNK_W(CHUNK_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .asg_valid (asg_valid),
    .asg_ready (asg_ready),
    .asg_data  (asg_data),
    .err_len   (err_len)
`ifdef ASG_COUNT_EN
    ,
    .asg_count (asg_count),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a complete frame is simply the first NBEATS beats laid end to end.
  function automatic wide_t pack_frame();
    wide_t r;
    for (int i = 0; i < TOTAL_W; i++) r[i] = beat_mem[i / CHUNK_W][i % CHUNK_W];
    return r;
  endfunction

  task automatic fill_random(input int len);
    for (int k = 0; k < MAXB; k++) beat_mem[k] = (k < len) ? $urandom : 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last sent beat's edge.
  task automatic send_frame(input int len, input int nsend, input bit burst);
    bit rdy;
    bit e_err;
    bit e_vld;
    int n;
    for (int k = 0; k < nsend; k++) begin
      if (!burst) begin
        int gap = $urandom_range(0, 2);
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = beat_mem[k];
      in_last  = (k == len - 1);
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 50) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!rdy) begin
        check("accept_timeout", wide_t'(1'b0), wide_t'(1'b1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      e_err = (len < NBEATS && k == len - 1) || (len > NBEATS && k == NBEATS - 1);
      e_vld = (len == NBEATS && k == NBEATS - 1);
      check("err_len_beat", wide_t'(err_len), wide_t'(e_err));
      check("asg_valid_beat", wide_t'(asg_valid), wide_t'(e_vld));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (nsend == len && len == NBEATS) begin
      check("in_ready_hold", wide_t'(in_ready), wide_t'(1'b0));
      check("asg_data", asg_data, pack_frame());
    end
  endtask

  task automatic finish_hold(input int stall);
    wide_t img = pack_frame();
    asg_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", wide_t'(asg_valid), wide_t'(1'b1));
      check("hold_in_ready", wide_t'(in_ready), wide_t'(1'b0));
      check("hold_data", asg_data, img);
    end
    asg_ready = 1'b1;
    @(posedge clk);
    #1;
    asg_ready = 1'b0;
    exp_good++;
    check("post_hs_valid", wide_t'(asg_valid), wide_t'(1'b0));
    check("post_hs_in_ready", wide_t'(in_ready), wide_t'(1'b1));
  endtask

  task automatic bad_frame(input int len);
    fill_random(len);
    send_frame(len, len, 1'b0);
    exp_bad++;
    @(posedge clk);
    #1;
    check("err_after", wide_t'(err_len), wide_t'(1'b0));
    check("no_valid_after_err", wide_t'(asg_valid), wide_t'(1'b0));
  endtask

  task automatic good_frame(input int stall);
    fill_random(NBEATS);
    send_frame(NBEATS, NBEATS, 1'b0);
    finish_hold(stall);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    asg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", wide_t'(asg_valid), wide_t'(1'b0));
    check("rst_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_valid", wide_t'(asg_valid), wide_t'(1'b0));
    check("rel_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    check("rel_err", wide_t'(err_len), wide_t'(1'b0));
    check("rel_data", asg_data, wide_t'(1'b0));

    // Happy path, back-to-back beats with asg_ready held high.
    for (int k = 0; k < MAXB; k++) beat_mem[k] = 32'h01010101 * k;
    asg_ready = 1'b1;
    send_frame(NBEATS, NBEATS, 1'b1);
    check("hp_lo", wide_t'(asg_data[31:0]), wide_t'(32'h0));
    check("hp_w1", wide_t'(asg_data[63:32]), wide_t'(32'h01010101));
    check("hp_top", wide_t'(asg_data[550:544]), wide_t'(7'h11));
    @(posedge clk);
    #1;
    asg_ready = 1'b0;
    exp_good++;
    check("hp_valid_one_cycle", wide_t'(asg_valid), wide_t'(1'b0));
    check("hp_in_ready_back", wide_t'(in_ready), wide_t'(1'b1));

    // Backpressure.
    good_frame(10);

    // Short frame, then a good one.
    fill_random(6);
    send_frame(6, 6, 1'b0);
    exp_bad++;
    @(posedge clk);
    #1;
    check("short_err_once", wide_t'(err_len), wide_t'(1'b0));
    good_frame(1);

    // Long frame, then a good one.
    bad_frame(20);
    good_frame(0);

    // Reset during beat 9.
    fill_random(NBEATS);
    send_frame(NBEATS, 9, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_fill_valid", wide_t'(asg_valid), wide_t'(1'b0));
    check("rst_fill_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_fill_err", wide_t'(err_len), wide_t'(1'b0));
    good_frame(2);

    // Reset during HOLD.
    fill_random(NBEATS);
    send_frame(NBEATS, NBEATS, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_hold_valid", wide_t'(asg_valid), wide_t'(1'b0));
    check("rst_hold_in_ready", wide_t'(in_ready), wide_t'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_err", wide_t'(err_len), wide_t'(1'b0));
    good_frame(0);

    // Randomized mix of frames.
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 3))
        0, 1: good_frame($urandom_range(0, 4));
        2: bad_frame($urandom_range(1, NBEATS - 1));
        default: bad_frame($urandom_range(NBEATS + 1, MAXB));
      endcase
    end

`ifdef ASG_COUNT_EN
    check("asg_count", wide_t'(asg_count), wide_t'(exp_good));
    check("err_count", wide_t'(err_count), wide_t'(exp_bad));
    force dut.r_asg_count = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.r_asg_count;
    good_frame(0);
    check("asg_count_wrap", wide_t'(asg_count), wide_t'(32'h0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
